// File: rtl/gpio_ctrl_apb_master_if.sv
// Bundle between the command/response client, the APB initiator and the GPIO APB target.
// "master" is the initiator's view (command sink, APB driver); "slave" is the environment's view.
interface gpio_ctrl_apb_master_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  cmd_write;
  logic [31:0]           cmd_wdata;
  logic [3:0]            cmd_strb;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_slverr;
  logic                  rsp_timeout;

  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [3:0]            pstrb;
  logic [31:0]           pwdata;
  logic [31:0]           prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  rsp_ready,
    output paddr, pwrite, psel, penable, pstrb, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output rsp_ready,
    input  paddr, pwrite, psel, penable, pstrb, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/gpio_ctrl_apb_master.sv
// Single-outstanding APB4 initiator turning a command/response handshake into APB transfers.
// Optional ACCESS-phase watchdog enabled by defining GPIO_CTRL_APB_TIMEOUT_EN.
module gpio_ctrl_apb_master #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gpio_ctrl_apb_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e state_q;
  state_e state_d;

  logic accept;
  logic done;
  logic timeout_hit;

  // cmd_ready depends only on state and reset, never on cmd_valid.
  assign bus.cmd_ready = (state_q == IDLE) && rst_n;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign done          = (state_q == ACCESS) && bus.pready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: non-blocking assignment keeps every register update order-independent within the edge.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    bus.psel      = 1'b0;
    bus.penable   = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        bus.psel = 1'b1;
        state_d  = ACCESS;
      end
      ACCESS: begin
        bus.psel    = 1'b1;
        bus.penable = 1'b1;
        if (done || timeout_hit) state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // APB request fields load on accept and are left alone until the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.paddr  <= '0;
      bus.pwrite <= 1'b0;
      bus.pwdata <= '0;
      bus.pstrb  <= '0;
    end else if (accept) begin
      bus.paddr  <= bus.cmd_addr;
      bus.pwrite <= bus.cmd_write;
      bus.pwdata <= bus.cmd_wdata;
      bus.pstrb  <= bus.cmd_write ? bus.cmd_strb : 4'h0;
    end
  end

  // Response capture; a normal completion always takes priority over the watchdog.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rsp_rdata  <= '0;
      bus.rsp_slverr <= 1'b0;
    end else if (done) begin
      bus.rsp_rdata  <= bus.pwrite ? 32'h0 : bus.prdata;
      bus.rsp_slverr <= bus.pslverr;
    end else if (timeout_hit) begin
      bus.rsp_rdata  <= 32'h0;
      bus.rsp_slverr <= 1'b1;
    end
  end

`ifdef GPIO_CTRL_APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  // Fires on the wait cycle that brings the count to TIMEOUT_CYCLES.
  assign timeout_hit     = (state_q == ACCESS) && !bus.pready && (wait_cnt == CNT_LAST);
  assign bus.rsp_timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_q == SETUP) begin
      wait_cnt <= '0;
    end else if ((state_q == ACCESS) && !bus.pready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (done) begin
      timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      timeout_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign bus.rsp_timeout    = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_gpio_ctrl_apb_master.sv
// Directed bench for gpio_ctrl_apb_master: latency, wait states, errors, stalls, mid-transfer reset.
// Timeout scenarios run only when GPIO_CTRL_APB_TIMEOUT_EN is defined.
module tb_gpio_ctrl_apb_master;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  gpio_ctrl_apb_master_if #(.ADDR_WIDTH(AW)) bus ();

  gpio_ctrl_apb_master #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [3:0] strb);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_write = wr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_write = 1'b0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    // Reset values
    step();
    step();
    check("rst_psel",        bus.psel,        0);
    check("rst_penable",     bus.penable,     0);
    check("rst_pwrite",      bus.pwrite,      0);
    check("rst_paddr",       bus.paddr,       0);
    check("rst_pstrb",       bus.pstrb,       0);
    check("rst_pwdata",      bus.pwdata,      0);
    check("rst_rsp_valid",   bus.rsp_valid,   0);
    check("rst_rsp_rdata",   bus.rsp_rdata,   0);
    check("rst_rsp_slverr",  bus.rsp_slverr,  0);
    check("rst_rsp_timeout", bus.rsp_timeout, 0);
    check("rst_cmd_ready",   bus.cmd_ready,   0);
    rst_n = 1'b1;
    #1;
    check("post_rst_cmd_ready", bus.cmd_ready, 1);

    // Write 0x004, zero wait states
    set_cmd(10'h004, 1'b1, 32'hDEADBEEF, 4'hF);
    bus.pready = 1'b1;
    step();                                   // accept edge N
    bus.cmd_valid = 1'b0;
    check("w_n1_psel",    bus.psel,    1);
    check("w_n1_penable", bus.penable, 0);
    check("w_n1_paddr",   bus.paddr,   32'h004);
    check("w_n1_pwdata",  bus.pwdata,  32'hDEADBEEF);
    check("w_n1_pstrb",   bus.pstrb,   32'hF);
    check("w_n1_pwrite",  bus.pwrite,  1);
    check("w_n1_cmd_rdy", bus.cmd_ready, 0);
    step();
    check("w_n2_psel",    bus.psel,    1);
    check("w_n2_penable", bus.penable, 1);
    check("w_n2_rsp_vld", bus.rsp_valid, 0);
    step();
    check("w_n3_rsp_vld", bus.rsp_valid,  1);
    check("w_n3_psel",    bus.psel,       0);
    check("w_n3_penable", bus.penable,    0);
    check("w_n3_rdata",   bus.rsp_rdata,  0);
    check("w_n3_slverr",  bus.rsp_slverr, 0);
    check("w_n3_timeout", bus.rsp_timeout, 0);
    bus.rsp_ready = 1'b1;
    bus.pready    = 1'b0;
    step();
    bus.rsp_ready = 1'b0;
    check("w_done_rsp_vld", bus.rsp_valid, 0);
    check("w_done_cmd_rdy", bus.cmd_ready, 1);
    check("w_done_paddr",   bus.paddr,     32'h004);

    // Read 0x200 with three wait states; prdata garbage until the completing cycle
    set_cmd(10'h200, 1'b0, 32'h12345678, 4'hF);
    bus.prdata = 32'hFFFF0000;
    step();                                   // accept edge N
    bus.cmd_valid = 1'b0;
    check("r_n1_pstrb", bus.pstrb,  0);
    check("r_n1_psel",  bus.psel,   1);
    check("r_n1_pwrite", bus.pwrite, 0);
    for (int i = 2; i <= 4; i++) begin
      step();
      check($sformatf("r_n%0d_penable", i), bus.penable, 1);
      check($sformatf("r_n%0d_pstrb", i),   bus.pstrb,   0);
    end
    step();                                   // N+5, completing ACCESS cycle
    bus.pready = 1'b1;
    bus.prdata = 32'h000000A5;
    check("r_n5_penable", bus.penable,   1);
    check("r_n5_rsp_vld", bus.rsp_valid, 0);
    step();                                   // N+6
    bus.pready = 1'b0;
    bus.prdata = 32'h0;
    check("r_n6_rsp_vld", bus.rsp_valid,  1);
    check("r_n6_rdata",   bus.rsp_rdata,  32'hA5);
    check("r_n6_slverr",  bus.rsp_slverr, 0);
    check("r_n6_psel",    bus.psel,       0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // Read 0x3F0 completing with an error on the first ACCESS cycle
    set_cmd(10'h3F0, 1'b0, 32'h0, 4'h0);
    bus.pready  = 1'b1;
    bus.pslverr = 1'b1;
    bus.prdata  = 32'h5A5A0001;
    step();
    bus.cmd_valid = 1'b0;
    step();
    check("e_access_penable", bus.penable, 1);
    step();
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    check("e_psel_after",  bus.psel,       0);
    check("e_rsp_vld",     bus.rsp_valid,  1);
    check("e_slverr",      bus.rsp_slverr, 1);
    check("e_rdata",       bus.rsp_rdata,  32'h5A5A0001);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // Back-to-back commands with cmd_valid held and a 5-cycle response stall
    set_cmd(10'h010, 1'b0, 32'h0, 4'h0);
    bus.pready = 1'b1;
    bus.prdata = 32'hCAFE0010;
    step();                                   // accept A
    set_cmd(10'h020, 1'b1, 32'h00000022, 4'h3);
    check("b2b_hold_cmd_rdy", bus.cmd_ready, 0);
    step();
    step();                                   // RESP for A
    bus.prdata = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("b2b_stall%0d_rsp_vld", i), bus.rsp_valid, 1);
      check($sformatf("b2b_stall%0d_rdata", i),   bus.rsp_rdata, 32'hCAFE0010);
      check($sformatf("b2b_stall%0d_slverr", i),  bus.rsp_slverr, 0);
      check($sformatf("b2b_stall%0d_cmd_rdy", i), bus.cmd_ready, 0);
      check($sformatf("b2b_stall%0d_paddr", i),   bus.paddr,     32'h010);
      if (i < 4) step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("b2b_idle_cmd_rdy", bus.cmd_ready, 1);
    check("b2b_idle_psel",    bus.psel,      0);
    check("b2b_idle_paddr",   bus.paddr,     32'h010);
    step();                                   // accept B
    bus.cmd_valid = 1'b0;
    check("b2b_b_psel",   bus.psel,   1);
    check("b2b_b_paddr",  bus.paddr,  32'h020);
    check("b2b_b_pwrite", bus.pwrite, 1);
    check("b2b_b_pstrb",  bus.pstrb,  32'h3);
    step();
    step();
    check("b2b_b_rsp_vld", bus.rsp_valid, 1);
    check("b2b_b_rdata",   bus.rsp_rdata, 0);
    bus.pready    = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // Reset pulse while in ACCESS discards the transfer
    set_cmd(10'h100, 1'b0, 32'h0, 4'h0);
    step();
    bus.cmd_valid = 1'b0;
    step();
    check("rstmid_penable", bus.penable, 1);
    rst_n = 1'b0;
    step();
    check("rstmid_psel",     bus.psel,      0);
    check("rstmid_penable0", bus.penable,   0);
    check("rstmid_rsp_vld",  bus.rsp_valid, 0);
    check("rstmid_cmd_rdy0", bus.cmd_ready, 0);
    rst_n      = 1'b1;
    bus.pready = 1'b1;
    #1;
    check("rstmid_cmd_rdy1", bus.cmd_ready, 1);
    step();
    step();
    check("rstmid_no_rsp", bus.rsp_valid, 0);
    check("rstmid_idle_psel", bus.psel, 0);
    bus.pready = 1'b0;

`ifdef GPIO_CTRL_APB_TIMEOUT_EN
    // Timeout after 16 ACCESS wait cycles
    set_cmd(10'h040, 1'b0, 32'h0, 4'h0);
    bus.prdata = 32'h99999999;
    step();
    bus.cmd_valid = 1'b0;
    step();                                   // ACCESS #1
    for (int i = 1; i < 16; i++) begin
      check($sformatf("to_access%0d_penable", i), bus.penable, 1);
      step();
    end
    check("to_access16_psel", bus.psel, 1);
    step();
    check("to_psel",    bus.psel,        0);
    check("to_penable", bus.penable,     0);
    check("to_rsp_vld", bus.rsp_valid,   1);
    check("to_slverr",  bus.rsp_slverr,  1);
    check("to_timeout", bus.rsp_timeout, 1);
    check("to_rdata",   bus.rsp_rdata,   0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // pready on the would-be timeout cycle: normal completion wins
    set_cmd(10'h044, 1'b0, 32'h0, 4'h0);
    step();
    bus.cmd_valid = 1'b0;
    step();
    for (int i = 1; i < 16; i++) step();
    bus.pready = 1'b1;
    bus.prdata = 32'h00000077;
    step();
    bus.pready = 1'b0;
    check("race_rsp_vld", bus.rsp_valid,   1);
    check("race_timeout", bus.rsp_timeout, 0);
    check("race_slverr",  bus.rsp_slverr,  0);
    check("race_rdata",   bus.rsp_rdata,   32'h77);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
`else
    // Without the watchdog a long wait never completes on its own
    set_cmd(10'h040, 1'b0, 32'h0, 4'h0);
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("nto_penable", bus.penable,     1);
    check("nto_rsp_vld", bus.rsp_valid,   0);
    check("nto_timeout", bus.rsp_timeout, 0);
    bus.pready = 1'b1;
    bus.prdata = 32'h00000033;
    step();
    bus.pready = 1'b0;
    check("nto_done_rdata",   bus.rsp_rdata,   32'h33);
    check("nto_done_timeout", bus.rsp_timeout, 0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
